// File: rtl/seg_pkg.sv
// seg_pkg: glyph constants and segment bit positions
// shared by the seven-segment scan driver files.
package seg_pkg;

  localparam logic [7:0] GLYPH_0    = 8'b1111_1100;
  localparam logic [7:0] GLYPH_1    = 8'b0110_0000;
  localparam logic [7:0] GLYPH_2    = 8'b1101_1010;
  localparam logic [7:0] GLYPH_3    = 8'b1111_0010;
  localparam logic [7:0] GLYPH_4    = 8'b0110_0110;
  localparam logic [7:0] GLYPH_5    = 8'b1011_0110;
  localparam logic [7:0] GLYPH_6    = 8'b1011_1110;
  localparam logic [7:0] GLYPH_7    = 8'b1110_0000;
  localparam logic [7:0] GLYPH_8    = 8'b1111_1110;
  localparam logic [7:0] GLYPH_9    = 8'b1111_0110;
  localparam logic [7:0] GLYPH_DASH = 8'b0000_0010;
  localparam logic [7:0] GLYPH_E    = 8'b1001_1110;
  localparam logic [7:0] SEG_OFF    = 8'b0000_0000;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

endpackage

// File: rtl/seg_glyph.sv
// seg_glyph: nibble -> a..g segment lookup (combinational).
// Ports: nib (hex nibble in), seg_ag (segments a..g, a = bit 6).
import seg_pkg::*;

module seg_glyph (
  input  logic [3:0] nib,
  output logic [6:0] seg_ag
);

  logic [7:0] g;

  always_comb begin
    g = GLYPH_E;
    unique case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_DASH;
      default: g = GLYPH_E;
    endcase
    seg_ag = g[SEG_A:SEG_G];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered multiplexed 7-seg scanner.
// Ports: clk, rst_n, data/load/dp_in/blink_en, lz_en -> seg, an, frame.
import seg_pkg::*;

module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic                  lz_en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]       psc;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       fcnt;
  logic                blink_phase;
  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, pend_blink;
  logic [DIGITS-1:0]   act_dp, act_blink;
  logic                pend_valid;

  logic                psc_tc, idx_last, frame_evt;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [3:0]          nib;
  logic                cur_dp, cur_blink, cur_supp;
  logic [6:0]          glyph_ag;
  logic [7:0]          seg_n;
  logic [DIGITS-1:0]   an_n;

  assign psc_tc    = (psc == PW'(SCAN_DIV - 1));
  assign idx_last  = (idx == IW'(DIGITS - 1));
  assign frame_evt = psc_tc && idx_last;

  // Blank leading zeros from the top digit down; digit 0 always shows.
  always_comb begin
    lz_mask  = '0;
    zero_run = lz_en;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (act_data[4*i +: 4] != 4'h0)
        zero_run = 1'b0;
      lz_mask[i] = zero_run;
    end
  end

  always_comb begin
    nib       = 4'h0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_supp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = act_data[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blink = act_blink[i];
        cur_supp  = lz_mask[i];
      end
    end
  end

  seg_glyph u_glyph (
    .nib    (nib),
    .seg_ag (glyph_ag)
  );

  // Prescaler slot 0 is the ghost guard: everything dark.
  always_comb begin
    seg_n = SEG_OFF;
    an_n  = '1;
    if (psc != '0) begin
      an_n[idx]          = 1'b0;
      seg_n[SEG_A:SEG_G] = cur_supp ? 7'b0 : glyph_ag;
      seg_n[SEG_DP]      = cur_dp;
      if (blink_phase && cur_blink)
        seg_n = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc         <= '0;
      idx         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_blink  <= '0;
      pend_valid  <= 1'b0;
      act_data    <= '0;
      act_dp      <= '0;
      act_blink   <= '0;
      seg         <= SEG_OFF;
      an          <= '1;
      frame       <= 1'b0;
    end else begin
      seg   <= seg_n;
      an    <= an_n;
      frame <= frame_evt;
      if (psc_tc) begin
        psc <= '0;
        idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
        psc <= psc + 1'b1;
      end
      if (frame_evt) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
        if (pend_valid) begin
          act_data  <= pend_data;
          act_dp    <= pend_dp;
          act_blink <= pend_blink;
        end
      end
      // A load in the commit cycle keeps pend_valid set for next frame.
      if (load) begin
        pend_data  <= data;
        pend_dp    <= dp_in;
        pend_blink <= blink_en;
        pend_valid <= 1'b1;
      end else if (frame_evt) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver
// (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_driver;

  localparam logic [7:0] G0 = 8'b1111_1100;
  localparam logic [7:0] G1 = 8'b0110_0000;
  localparam logic [7:0] G2 = 8'b1101_1010;
  localparam logic [7:0] G3 = 8'b1111_0010;
  localparam logic [7:0] G4 = 8'b0110_0110;
  localparam logic [7:0] G5 = 8'b1011_0110;
  localparam logic [7:0] GD = 8'b0000_0010;
  localparam logic [7:0] GE = 8'b1001_1110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_en = '0;
  logic        lz_en = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] cap_seg [4];
  logic [3:0] cap_an  [4];
  int         cap_ph;

  seg_scan_driver #(
    .DIGITS       (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .load     (load),
    .dp_in    (dp_in),
    .blink_en (blink_en),
    .lz_en    (lz_en),
    .seg      (seg),
    .an       (an),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after the last reset edge.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_pulse(input logic [15:0] d);
    data = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (frame) found = 1;
    end
    chk("frame_seen", 16'(found), 16'd1);
  endtask

  // Starts at a frame-pulse negedge, ends at the next one.
  task automatic capture(input int ka, input logic [15:0] da,
                         input int kb, input logic [15:0] db);
    bit ok = 1;
    int d, p;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k == 1) cap_ph = ((cyc / 16) / 2) % 2;
      d = (k - 1) / 4;
      p = (k - 1) % 4;
      if (p == 0) begin
        if (an !== 4'hF || seg !== 8'h00) ok = 0;
      end else if (p == 1) begin
        cap_seg[d] = seg;
        cap_an[d]  = an;
      end else if (seg !== cap_seg[d] || an !== cap_an[d]) begin
        ok = 0;
      end
      if (frame !== (k == 16)) ok = 0;
      if (k == ka) begin data = da; load = 1'b1; end
      if (k == kb) begin data = db; load = 1'b1; end
    end
    chk("scan_stable", 16'(ok), 16'd1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_seg", 16'(seg), 16'h00);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_frame", 16'(frame), 16'd0);

    rst_n = 1'b1;
    load_pulse(16'h1234);
    wait_frame();
    capture(0, '0, 0, '0);
    chk("d0_1234", 16'(cap_seg[0]), 16'(G4));
    chk("an0_1234", 16'(cap_an[0]), 16'hE);
    chk("d1_1234", 16'(cap_seg[1]), 16'(G3));
    chk("d2_1234", 16'(cap_seg[2]), 16'(G2));
    chk("d3_1234", 16'(cap_seg[3]), 16'(G1));
    chk("an3_1234", 16'(cap_an[3]), 16'h7);

    lz_en = 1'b1;
    load_pulse(16'h00A5);
    wait_frame();
    capture(0, '0, 0, '0);
    chk("lz_d3", 16'(cap_seg[3]), 16'h00);
    chk("lz_an3", 16'(cap_an[3]), 16'h7);
    chk("lz_d2", 16'(cap_seg[2]), 16'h00);
    chk("lz_d1", 16'(cap_seg[1]), 16'(GD));
    chk("lz_d0", 16'(cap_seg[0]), 16'(G5));
    lz_en = 1'b0;
    capture(0, '0, 0, '0);
    chk("nolz_d3", 16'(cap_seg[3]), 16'(G0));
    chk("nolz_d2", 16'(cap_seg[2]), 16'(G0));

    lz_en = 1'b1;
    dp_in = 4'b0100;
    load_pulse(16'h0000);
    dp_in = 4'b0000;
    wait_frame();
    capture(0, '0, 0, '0);
    chk("z_d0", 16'(cap_seg[0]), 16'(G0));
    chk("z_d1", 16'(cap_seg[1]), 16'h00);
    chk("z_d2dp", 16'(cap_seg[2]), 16'h01);
    chk("z_d3", 16'(cap_seg[3]), 16'h00);
    lz_en = 1'b0;

    load_pulse(16'h1111);
    wait_frame();
    capture(6, 16'h2222, 0, '0);
    chk("db_old_d0", 16'(cap_seg[0]), 16'(G1));
    chk("db_old_d3", 16'(cap_seg[3]), 16'(G1));
    capture(0, '0, 0, '0);
    chk("db_new_d0", 16'(cap_seg[0]), 16'(G2));
    chk("db_new_d3", 16'(cap_seg[3]), 16'(G2));

    data = 16'h3333;
    load = 1'b1;
    capture(0, '0, 0, '0);
    chk("fp_hold", 16'(cap_seg[0]), 16'(G2));
    capture(5, 16'h4444, 15, 16'h5555);
    chk("fp_commit", 16'(cap_seg[0]), 16'(G3));
    capture(0, '0, 0, '0);
    chk("ev_old", 16'(cap_seg[1]), 16'(G4));
    capture(0, '0, 0, '0);
    chk("ev_new", 16'(cap_seg[2]), 16'(G5));

    blink_en = 4'b0001;
    data = 16'hFFFF;
    load = 1'b1;
    capture(0, '0, 0, '0);
    blink_en = 4'b0000;
    for (int f = 0; f < 4; f++) begin
      capture(0, '0, 0, '0);
      chk("blink_d0", 16'(cap_seg[0]),
          cap_ph != 0 ? 16'h00 : 16'(GE));
      chk("blink_an0", 16'(cap_an[0]), 16'hE);
      chk("steady_d1", 16'(cap_seg[1]), 16'(GE));
      chk("steady_d3", 16'(cap_seg[3]), 16'(GE));
    end

    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_seg", 16'(seg), 16'h00);
    chk("mid_rst_frame", 16'(frame), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_guard", 16'(an), 16'hF);
    @(negedge clk);
    chk("restart_an", 16'(an), 16'hE);
    chk("restart_seg", 16'(seg), 16'(G0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
